// File: rtl/src_pkg.sv
// Shared definitions for the ping-pong source buffer: loader FSM states and
// the bank constants the loader and p_ctrl both rely on.
package src_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} ld_state_t;

    localparam int   BANKS   = 2;
    localparam logic P_RESET = 1'b1;

endpackage

// File: rtl/src_loader_if.sv
// Valid/ready word stream feeding the source loader.
interface src_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/bank_cnt.sv
// Per-bank word counter: supplies the write address and flags the accepted
// word that closes the bank (terminal count or end of stream).
module bank_cnt #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc,
    input  logic              last,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   cnt_inc,
    output logic              close
);
    localparam logic [ADDR_W:0] TERM = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] wcnt_d, wcnt_q;

    assign waddr   = wcnt_q[ADDR_W-1:0];
    assign cnt_inc = wcnt_q + (ADDR_W+1)'(1);
    assign close   = acc & (last | (cnt_inc == TERM));

    always_comb begin
        wcnt_d = wcnt_q;
        if (clr || close) begin
            wcnt_d = '0;
        end else if (acc) begin
            wcnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

endmodule

// File: rtl/src_loader.sv
// Producer side of the ping-pong source buffer: streams words into the free
// bank, publishes full banks on src_en and frees them on s_fin_in.
module src_loader
    import src_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    src_loader_if.slave       s,
    input  logic              p,
    input  logic              s_fin_in,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [BANKS-1:0]  src_en,
    output logic [ADDR_W:0]   len0,
    output logic [ADDR_W:0]   len1,
    output logic              src_fin
);
    ld_state_t         state_d, state_q;
    logic              wp_d, wp_q;
    logic [BANKS-1:0]  src_en_d, src_en_q;
    logic [ADDR_W:0]   len0_d, len0_q, len1_d, len1_q;
    logic              src_fin_d, src_fin_q;
    logic              wr_en_d, wr_en_q, wr_bank_d, wr_bank_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic [DATA_W-1:0] wr_data_d, wr_data_q;
    logic              close_d, close_q, last_d, last_q;
    logic [ADDR_W:0]   plen_d, plen_q;

    logic              ready, acc, close;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   cnt_inc;

    assign ready     = (state_q == FILL) & ~src_en_q[wp_q];
    assign acc       = s.s_valid & ready;
    assign s.s_ready = ready;

    bank_cnt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (~run),
        .acc     (acc),
        .last    (s.s_last),
        .waddr   (waddr),
        .cnt_inc (cnt_inc),
        .close   (close)
    );

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        src_en_d  = src_en_q;
        len0_d    = len0_q;
        len1_d    = len1_q;
        src_fin_d = src_fin_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        close_d   = 1'b0;
        last_d    = 1'b0;
        plen_d    = plen_q;
        if (!run) begin
            state_d   = IDLE;
            wp_d      = P_RESET;
            src_en_d  = '0;
            len0_d    = '0;
            len1_d    = '0;
            src_fin_d = 1'b0;
            wr_bank_d = P_RESET;
            wr_addr_d = '0;
            wr_data_d = '0;
            plen_d    = '0;
        end else begin
            if (s_fin_in) begin
                src_en_d[p] = 1'b0;
            end
            // Publish a closed bank one edge late, when its last write lands.
            if (close_q) begin
                src_en_d[wr_bank_q] = 1'b1;
                if (wr_bank_q) len1_d = plen_q;
                else           len0_d = plen_q;
                if (last_q) src_fin_d = 1'b1;
            end
            if (acc) begin
                wr_en_d   = 1'b1;
                wr_bank_d = wp_q;
                wr_addr_d = waddr;
                wr_data_d = s.s_data;
            end
            if (close) begin
                close_d = 1'b1;
                last_d  = s.s_last;
                plen_d  = cnt_inc;
                wp_d    = ~wp_q;
            end
            case (state_q)
                IDLE: state_d = FILL;
                // A free returned on this same edge counts, so no bubble.
                FILL: if (close) state_d = s.s_last ? DONE
                                         : (src_en_d[~wp_q] ? WAIT : FILL);
                WAIT: if (!src_en_q[wp_q]) state_d = FILL;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wp_q      <= P_RESET;
            src_en_q  <= '0;
            len0_q    <= '0;
            len1_q    <= '0;
            src_fin_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= P_RESET;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            close_q   <= 1'b0;
            last_q    <= 1'b0;
            plen_q    <= '0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            src_en_q  <= src_en_d;
            len0_q    <= len0_d;
            len1_q    <= len1_d;
            src_fin_q <= src_fin_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            close_q   <= close_d;
            last_q    <= last_d;
            plen_q    <= plen_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_bank = wr_bank_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign src_en  = src_en_q;
    assign len0    = len0_q;
    assign len1    = len1_q;
    assign src_fin = src_fin_q;

endmodule

// File: tb/tb_src_loader.sv
// Directed-plus-random bench for src_loader: words of a job are mapped to
// bank/address by chunk arithmetic and bank flags are tracked per transaction.
module tb_src_loader;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst, run, p, s_fin_in;
    logic              wr_en, wr_bank, src_fin;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        src_en;
    logic [ADDR_W:0]   len0, len1;

    int n_pass = 0;
    int n_chk  = 0;

    src_loader_if #(.DATA_W(DATA_W)) sif ();

    src_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .s        (sif),
        .p        (p),
        .s_fin_in (s_fin_in),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .src_en   (src_en),
        .len0     (len0),
        .len1     (len1),
        .src_fin  (src_fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Word i of a job lands in chunk i/DEPTH; chunks alternate starting at bank 1.
    function automatic bit bank_of(input int i);
        return ((i / DEPTH) % 2 == 0);
    endfunction

    function automatic bit closes(input int i, input int n);
        return (i % DEPTH == DEPTH - 1) || (i == n - 1);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".s_ready"}, sif.s_ready, 0);
        check({tag, ".wr_en"},   wr_en,   0);
        check({tag, ".wr_bank"}, wr_bank, 1);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".wr_data"}, wr_data, 0);
        check({tag, ".src_en"},  src_en,  0);
        check({tag, ".len0"},    len0,    0);
        check({tag, ".len1"},    len1,    0);
        check({tag, ".src_fin"}, src_fin, 0);
    endtask

    task automatic drop_run();
        run = 1'b0;
        @(posedge clk); #1;
        check_reset("run_low");
    endtask

    // mode 0: no frees; 1: random frees; 2: frees coincide with closes;
    // 3: free only while stalled. abort >= 0 pulses rst when word abort is up.
    task automatic run_job(input int n, input int mode, input bit hold, input int abort);
        logic [DATA_W-1:0] words[$];
        bit [1:0] m_en = 2'b00;
        int  m_len[2] = '{0, 0};
        bit  m_fin = 0, pm = 1'b1, fb;
        bit  pend_close = 0, pend_bank = 0, pend_last = 0;
        int  pend_len = 0, idx = 0, cyc = 0;
        bit  acc_now, fin_now, fin_prev = 0, due_rdy = 0, clr_hit;
        for (int i = 0; i < n; i++) words.push_back($urandom);
        check_reset("start");
        run = 1'b1; p = 1'b1; s_fin_in = 1'b0; sif.s_valid = 1'b0;
        @(posedge clk); #1;
        check("start_rdy", sif.s_ready, 1);
        while (cyc < 2000 && !(idx == n && !pend_close)) begin
            cyc++;
            if (idx == abort) begin
                sif.s_valid = 1'b1; sif.s_data = words[idx]; sif.s_last = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset("rst_async");
                @(posedge clk); #1;
                check_reset("rst_held");
                rst = 1'b0; sif.s_valid = 1'b0;
                return;
            end
            if (idx < n) begin
                sif.s_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
                sif.s_data  = words[idx];
                sif.s_last  = (idx == n - 1);
            end else begin
                sif.s_valid = 1'b0;
            end
            acc_now = sif.s_valid & sif.s_ready;
            fin_now = 1'b0;
            if (!fin_prev && m_en[pm]) begin
                case (mode)
                    1: fin_now = ($urandom_range(0, 2) == 0);
                    2: fin_now = (acc_now && closes(idx, n) && pm != bank_of(idx)) ||
                                 (!sif.s_ready && idx < n);
                    3: fin_now = !sif.s_ready && idx < n;
                    default: fin_now = 1'b0;
                endcase
            end
            s_fin_in = fin_now; p = pm;
            @(posedge clk); #1;
            clr_hit = 1'b0;
            if (fin_now) begin
                fb = pm; m_en[fb] = 1'b0; pm = ~pm;
                clr_hit = !acc_now && idx < n && fb == bank_of(idx);
            end
            if (pend_close) begin
                m_en[pend_bank] = 1'b1; m_len[pend_bank] = pend_len;
                if (pend_last) m_fin = 1'b1;
                pend_close = 1'b0;
            end
            check("wr_en", wr_en, acc_now);
            if (acc_now) begin
                check("wr_bank", wr_bank, bank_of(idx));
                check("wr_addr", wr_addr, idx % DEPTH);
                check("wr_data", wr_data, words[idx]);
                if (closes(idx, n)) begin
                    pend_close = 1'b1; pend_bank = bank_of(idx);
                    pend_len = idx % DEPTH + 1; pend_last = (idx == n - 1);
                end
                idx++;
            end
            check("src_en", src_en, m_en);
            check("src_fin", src_fin, m_fin);
            if (m_en[0]) check("len0", len0, m_len[0]);
            if (m_en[1]) check("len1", len1, m_len[1]);
            if (due_rdy) begin
                check("wait_release", sif.s_ready, 1);
                due_rdy = 1'b0;
            end
            if (clr_hit) begin
                check("wait_one_edge", sif.s_ready, 0);
                due_rdy = 1'b1;
            end else if (acc_now && idx < n) begin
                check("no_bubble", sif.s_ready, !m_en[bank_of(idx)]);
            end
            if (idx >= n) check("done_rdy0", sif.s_ready, 0);
            fin_prev = fin_now;
        end
        s_fin_in = 1'b0; sif.s_valid = 1'b0;
        check("job_words", idx, n);
        check("job_fin", src_fin, 1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; p = 1'b1; s_fin_in = 1'b0;
        sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
        #1 check_reset("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_reset("idle_run0");
        run_job(8, 0, 0, -1);
        check("a.src_en", src_en, 2'b11);
        check("a.len0", len0, 4);
        check("a.len1", len1, 4);
        drop_run();
        run_job(11, 3, 0, -1);
        check("b.len1", len1, 3);
        check("b.src_en", src_en, 2'b11);
        drop_run();
        run_job(1, 0, 0, -1);
        check("c.src_en", src_en, 2'b10);
        check("c.len1", len1, 1);
        drop_run();
        run_job(14, 2, 1, -1);
        drop_run();
        run_job(10, 0, 1, 6);
        run_job(6, 0, 0, -1);
        drop_run();
        for (int k = 0; k < 3; k++) begin
            run_job(23, 1, 0, -1);
            drop_run();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
